// File: rtl/pc_unit.sv
// pc_unit: registered program counter with increment, absolute jump,
// signed relative branch, stall, and call/return through an internal
// return-address stack. All outputs come from registers or from
// registered state only; there is no combinational input-to-output path.
module pc_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                STEP       = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int                OFF_W      = 8,
    parameter int                RAS_DEPTH  = 4,
    localparam int               CNT_W      = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next,
    input  logic              stall,
    input  logic              jump,
    input  logic              branch,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] addr_out,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              err
);

    localparam int IDX_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_step;
    logic [ADDR_W-1:0] pc_branch;
    logic              stk_empty;
    logic              stk_full;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              do_push;

    // Sums wrap modulo 2^ADDR_W; the offset cast sign-extends it first.
    assign pc_step   = pc + ADDR_W'(STEP);
    assign pc_branch = pc + ADDR_W'($signed(offset));

    assign stk_empty = (cnt == '0);
    assign stk_full  = (cnt == CNT_W'(RAS_DEPTH));

    // Indices are only used when in range (push needs !full, pop needs !empty).
    assign push_idx = IDX_W'(cnt);
    assign top_idx  = IDX_W'(cnt - CNT_W'(1));

    // A push happens only when call is the winning command and there is room.
    assign do_push = !rst && !stall && !ret && call && !stk_full;

    // Stack storage: contents above the count are never read, so no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            ras_mem[push_idx] <= pc_step;
    end

    // PC, stack count and sticky error, in command priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_ADDR;
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (stk_empty) begin
                    err_q <= 1'b1;
                end else begin
                    pc  <= ras_mem[top_idx];
                    cnt <= cnt - CNT_W'(1);
                end
            end else if (call) begin
                pc <= addr_in;
                if (stk_full)
                    err_q <= 1'b1;
                else
                    cnt <= cnt + CNT_W'(1);
            end else if (jump) begin
                pc <= addr_in;
            end else if (branch) begin
                pc <= pc_branch;
            end else if (next) begin
                pc <= pc_step;
            end
        end
    end

    assign addr_out  = pc;
    assign ras_count = cnt;
    assign ras_empty = stk_empty;
    assign ras_full  = stk_full;
    assign err       = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand-written corner sequences,
// then randomized commands checked against a queue-based reference model.
module tb_pc_unit;

    // Command mask layout: {rst, stall, ret, call, jump, branch, next}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b1000000;
    localparam logic [6:0] C_STL  = 7'b0100000;
    localparam logic [6:0] C_RET  = 7'b0010000;
    localparam logic [6:0] C_CALL = 7'b0001000;
    localparam logic [6:0] C_JMP  = 7'b0000100;
    localparam logic [6:0] C_BR   = 7'b0000010;
    localparam logic [6:0] C_NXT  = 7'b0000001;

    typedef struct {
        logic [6:0]  cmd;
        logic [15:0] ain;
        logic [7:0]  off;
        logic [15:0] e_addr;
        int          e_cnt;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, nxt, jmp, br, cl, rt;
    logic [15:0] addr_in;
    logic [7:0]  offset;
    logic [15:0] addr_out;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk      (clk),
        .rst      (rst),
        .next     (nxt),
        .stall    (stall),
        .jump     (jmp),
        .branch   (br),
        .call     (cl),
        .ret      (rt),
        .addr_in  (addr_in),
        .offset   (offset),
        .addr_out (addr_out),
        .ras_count(ras_count),
        .ras_empty(ras_empty),
        .ras_full (ras_full),
        .err      (err)
    );

    function automatic vec_t v(logic [6:0] c, logic [15:0] a, logic [7:0] o,
                               logic [15:0] ea, int ec, logic ee);
        vec_t r;
        r.cmd = c; r.ain = a; r.off = o;
        r.e_addr = ea; r.e_cnt = ec; r.e_err = ee;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of commands, then sample 1 time unit after the edge.
    task automatic apply(input logic [6:0] c, input logic [15:0] a, input logic [7:0] o);
        {rst, stall, rt, cl, jmp, br, nxt} = c;
        addr_in = a;
        offset  = o;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [15:0] ea, input int ec, input logic ee);
        chk({tag, ".addr"},  32'(addr_out),  32'(ea));
        chk({tag, ".count"}, 32'(ras_count), 32'(ec));
        chk({tag, ".empty"}, 32'(ras_empty), 32'(ec == 0));
        chk({tag, ".full"},  32'(ras_full),  32'(ec == 4));
        chk({tag, ".err"},   32'(err),       32'(ee));
    endtask

    task automatic step(input string tag, input logic [6:0] c, input logic [15:0] a,
                        input logic [7:0] o, input logic [15:0] ea, input int ec, input logic ee);
        apply(c, a, o);
        expect_st(tag, ea, ec, ee);
    endtask

    // Reference model state: plain PC value, queue as LIFO, sticky error.
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_err;

    task automatic model(input logic [6:0] c, input logic [15:0] a, input logic [7:0] o);
        if (c[6]) begin
            m_pc = 16'h0000; m_stk.delete(); m_err = 1'b0;
        end else if (c[5]) begin
            // frozen
        end else if (c[4]) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (c[3]) begin
            if (m_stk.size() == 4) m_err = 1'b1;
            else m_stk.push_back(16'(m_pc + 16'd1));
            m_pc = a;
        end else if (c[2]) begin
            m_pc = a;
        end else if (c[1]) begin
            m_pc = 16'(int'(m_pc) + int'($signed(o)));
        end else if (c[0]) begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    vec_t tbl[$];

    initial begin
        {rst, stall, rt, cl, jmp, br, nxt} = C_NONE;
        addr_in = '0;
        offset  = '0;

        // Reset, increment, wrap, branches, same-cycle priority, nested calls/rets
        tbl.push_back(v(C_RST, 16'h0, 8'h0, 16'h0000, 0, 0));
        tbl.push_back(v(C_NXT, 16'h0, 8'h0, 16'h0001, 0, 0));
        tbl.push_back(v(C_NXT, 16'h0, 8'h0, 16'h0002, 0, 0));
        tbl.push_back(v(C_NXT, 16'h0, 8'h0, 16'h0003, 0, 0));
        tbl.push_back(v(C_JMP, 16'hFFFF, 8'h0, 16'hFFFF, 0, 0));
        tbl.push_back(v(C_NXT, 16'h0, 8'h0, 16'h0000, 0, 0));
        tbl.push_back(v(C_JMP, 16'h0100, 8'h0, 16'h0100, 0, 0));
        tbl.push_back(v(C_BR,  16'h0, 8'hFE, 16'h00FE, 0, 0));
        tbl.push_back(v(C_BR,  16'h0, 8'h7F, 16'h017D, 0, 0));
        tbl.push_back(v(C_JMP | C_BR | C_NXT, 16'h0200, 8'h05, 16'h0200, 0, 0));
        tbl.push_back(v(C_JMP,  16'h0010, 8'h0, 16'h0010, 0, 0));
        tbl.push_back(v(C_CALL, 16'h1000, 8'h0, 16'h1000, 1, 0));
        tbl.push_back(v(C_CALL, 16'h2000, 8'h0, 16'h2000, 2, 0));
        tbl.push_back(v(C_CALL, 16'h3000, 8'h0, 16'h3000, 3, 0));
        tbl.push_back(v(C_CALL, 16'h4000, 8'h0, 16'h4000, 4, 0));
        tbl.push_back(v(C_RET,  16'h0, 8'h0, 16'h3001, 3, 0));
        tbl.push_back(v(C_RET,  16'h0, 8'h0, 16'h2001, 2, 0));
        tbl.push_back(v(C_RET,  16'h0, 8'h0, 16'h1001, 1, 0));
        tbl.push_back(v(C_RET,  16'h0, 8'h0, 16'h0011, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            apply(tbl[i].cmd, tbl[i].ain, tbl[i].off);
            expect_st($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_cnt, tbl[i].e_err);
        end

        // Overflow on a full stack, then pops and underflow
        step("ovf.j",  C_JMP,  16'h0010, 8'h0, 16'h0010, 0, 0);
        step("ovf.c1", C_CALL, 16'h1000, 8'h0, 16'h1000, 1, 0);
        step("ovf.c2", C_CALL, 16'h2000, 8'h0, 16'h2000, 2, 0);
        step("ovf.c3", C_CALL, 16'h3000, 8'h0, 16'h3000, 3, 0);
        step("ovf.c4", C_CALL, 16'h4000, 8'h0, 16'h4000, 4, 0);
        step("ovf.c5", C_CALL, 16'h5000, 8'h0, 16'h5000, 4, 1);
        step("ovf.r1", C_RET,  16'h0, 8'h0, 16'h3001, 3, 1);
        step("ovf.r2", C_RET,  16'h0, 8'h0, 16'h2001, 2, 1);
        step("ovf.r3", C_RET,  16'h0, 8'h0, 16'h1001, 1, 1);
        step("ovf.r4", C_RET,  16'h0, 8'h0, 16'h0011, 0, 1);
        step("unf.r",  C_RET,  16'h0, 8'h0, 16'h0011, 0, 1);
        step("unf.n",  C_NXT,  16'h0, 8'h0, 16'h0012, 0, 1);

        // Stall overrides call and next; release resumes
        step("stl.c",  C_CALL, 16'h1234, 8'h0, 16'h1234, 1, 1);
        step("stl.s1", C_STL | C_CALL | C_NXT, 16'h5555, 8'h0, 16'h1234, 1, 1);
        step("stl.s2", C_STL | C_CALL | C_NXT | C_RET, 16'h5555, 8'h0, 16'h1234, 1, 1);
        step("stl.n",  C_NXT,  16'h0, 8'h0, 16'h1235, 1, 1);

        // Reset beats a simultaneous call; stack is invalidated
        step("rc.c",   C_CALL, 16'h2000, 8'h0, 16'h2000, 2, 1);
        step("rc.rst", C_RST | C_CALL, 16'h3000, 8'h0, 16'h0000, 0, 0);
        step("rc.ret", C_RET,  16'h0, 8'h0, 16'h0000, 0, 1);

        // Call immediately followed by ret returns the value just pushed
        step("br.c",   C_CALL, 16'h0AAA, 8'h0, 16'h0AAA, 1, 1);
        step("br.r",   C_RET,  16'h0, 8'h0, 16'h0001, 0, 1);

        // Randomized commands against the reference model
        apply(C_RST, 16'h0, 8'h0);
        model(C_RST, 16'h0, 8'h0);
        for (int i = 0; i < 400; i++) begin
            logic [6:0]  c;
            logic [15:0] a;
            logic [7:0]  o;
            c[6] = ($urandom_range(0, 49) == 0);
            c[5] = ($urandom_range(0, 7) == 0);
            for (int b = 0; b < 5; b++) c[b] = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            o = 8'($urandom);
            apply(c, a, o);
            model(c, a, o);
            expect_st($sformatf("rnd%0d", i), m_pc, m_stk.size(), m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit, the next generation of the 16-bit PC adder. It keeps a registered instruction address and supports increment, absolute jump, signed relative branch, stall, and call/return through an internal return-address stack (RAS) of configurable depth. It sits between the control FSM and instruction memory. Its `addr_out` drives the instruction-memory address bus directly.

## Interface
Parameters:
- `ADDR_W`, 16, address width in bits.
- `STEP`, 1, increment added on `next` and pushed as return offset on `call`.
- `RESET_ADDR`, 0, value loaded into the PC on reset.
- `OFF_W`, 8, width of the signed branch offset.
- `RAS_DEPTH`, 4, number of return-address stack entries (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `next`  in  1  advance PC by `STEP`.
- `stall`  in  1  freeze PC and stack; overrides all commands except `rst`.
- `jump`  in  1  load `addr_in` into PC.
- `branch`  in  1  PC += sign-extended `offset`.
- `call`  in  1  push PC+`STEP` on RAS, then load `addr_in`.
- `ret`  in  1  pop RAS top into PC.
- `addr_in`  in  ADDR_W  jump/call target.
- `offset`  in  OFF_W  signed (two's complement) branch offset.
- `addr_out`  out  ADDR_W  registered current PC.
- `ras_count`  out  clog2(RAS_DEPTH+1)  valid stack entries.
- `ras_empty`  out  1  `ras_count`==0.
- `ras_full`  out  1  `ras_count`==RAS_DEPTH.
- `err`  out  1  sticky: RAS overflow or underflow since reset.

## Operation
- Command priority per cycle: `rst` > `stall` > `ret` > `call` > `jump` > `branch` > `next` > hold. Only the highest asserted command executes. Lower-priority commands in the same cycle are dropped, not queued.
- Arithmetic: all PC sums are modulo 2^ADDR_W and wrap silently. `offset` is sign-extended to ADDR_W before the add. `err` does not flag wrap.
- `call` pushes (PC+STEP) mod 2^ADDR_W into slot `ras_count`, increments the count, and sets PC=`addr_in`.
- `call` with `ras_full`: PC still loads `addr_in`, the push is discarded, the stack is unchanged, and `err` is set.
- `ret` pops the entry at `ras_count-1` into PC and decrements the count.
- `ret` with `ras_empty`: PC holds, count stays 0, and `err` is set.
- Stack is LIFO. Entries above `ras_count` are don't-care and are not observable.
- `err` stays set until `rst`. It does not otherwise block operation.

## Timing
- Reset values, one edge after `rst`=1 is sampled:
  - `addr_out`=RESET_ADDR, `ras_count`=0, `ras_empty`=1, `ras_full`=0, `err`=0.
- `rst` wins over every other input. Reset mid-call or mid-return discards the command. Stack contents are invalidated through count=0.
- Latency: a command sampled at edge N is visible on `addr_out`, `ras_*` and `err` after edge N. All outputs are registered, with no combinational input-to-output path.
- `stall`=1: every output holds its previous value, including when `call` or `ret` is also asserted.
- Back-to-back commands on consecutive cycles are legal. A `ret` in the cycle right after a `call` returns the value just pushed.
- Command inputs are level-sampled each edge. Holding `next` for k cycles advances the PC by k·STEP.

## Test plan
All cases use defaults: ADDR_W=16, STEP=1, OFF_W=8, RAS_DEPTH=4, RESET_ADDR=0.

1. Reset then `next` held 3 cycles → `addr_out` 0x0000, 0x0001, 0x0002, 0x0003. Set PC=0xFFFF by `jump`, then `next` → 0x0000 (wrap), `err`=0.
2. Jump to 0x0100, then branch with offset 0xFE (−2) → 0x00FE. Then branch with offset 0x7F → 0x017D. Same cycle `jump`+`branch`+`next` with `addr_in`=0x0200 → 0x0200 only.
3. Four nested calls from PC 0x0010 to targets 0x1000/0x2000/0x3000/0x4000 → `ras_full`=1, count=4. Four rets → PC 0x3001, 0x2001, 0x1001, 0x0011, then `ras_empty`=1.
4. Fifth `call` when full → PC=`addr_in`, count stays 4, `err`=1. Subsequent `ret` returns the 4th pushed address. `ret` on empty → PC holds, `err` stays 1 until `rst`.
5. `stall`=1 together with `call` and `next` for 2 cycles → `addr_out`, `ras_count` and `err` unchanged. Release → normal operation resumes.
6. `rst` asserted in the same cycle as `call`, with count=2 → next edge gives `addr_out`=0x0000, count=0, `err`=0. A following `ret` flags underflow.
